// File: rtl/camac_cycle_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : camac_cycle_arbiter
//  Description : Sequences single CAMAC dataway cycles through the
//                micro-program automate on behalf of two requesters, the ISA
//                host port (HOST) and the LAM-service poller (LAM).
//                Arbitrates, presents a/w with a setup window before sel_n,
//                waits for the automate's rdy low/high handshake and reports
//                done (and timeout_err on abort) to the winning requester.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SETUP_CYCLES   : clocks a/w are stable before sel_n asserts (1..15)
//    TIMEOUT_CYCLES : max clocks sel_n stays low before the cycle is aborted
//                     (2..1023)
//  Build option
//    ARB_LAM_PRIORITY_EN : when defined, LAM wins every tie (fixed priority);
//                          otherwise ties are resolved round-robin.
//  Ports
//    clk, reset              : clock, synchronous active-high reset
//    host_req/host_a/host_w  : HOST request level, subaddress, direction
//    host_done               : HOST cycle finished (one-clock pulse)
//    lam_req/lam_a/lam_w     : LAM request level, subaddress, direction
//    lam_done                : LAM cycle finished (one-clock pulse)
//    a, w, sel_n             : subaddress, direction, select to automate
//    rdy                     : automate ready (low while cycle in progress)
//    busy                    : high in every state except IDLE
//    timeout_err             : pulses with done when the cycle was aborted
//    grant_lam               : owner of current/last cycle (0 HOST, 1 LAM)
// ============================================================================
module camac_cycle_arbiter #(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_req,
    input  logic [1:0] host_a,
    input  logic       host_w,
    output logic       host_done,
    input  logic       lam_req,
    input  logic [1:0] lam_a,
    input  logic       lam_w,
    output logic       lam_done,
    output logic [1:0] a,
    output logic       w,
    output logic       sel_n,
    input  logic       rdy,
    output logic       busy,
    output logic       timeout_err,
    output logic       grant_lam
);

    localparam int         c_CNT_W     = 10;
    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_SETUP   = 3'd1;
    localparam logic [2:0] c_S_WAIT_LO = 3'd2;
    localparam logic [2:0] c_S_WAIT_HI = 3'd3;
    localparam logic [2:0] c_S_RELEASE = 3'd4;

    // The setup counter is loaded with N-1 so that sel_n falls exactly
    // SETUP_CYCLES edges after the request is accepted.
    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT    = c_CNT_W'(TIMEOUT_CYCLES);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               r_timeout;
    logic               w_timeout_nxt;
    logic               w_start;
    logic               w_pick_lam;
    logic [1:0]         r_a;
    logic               r_w;
    logic               r_grant_lam;

    // Winner selection, only consulted on the IDLE->SETUP edge.
`ifdef ARB_LAM_PRIORITY_EN
    assign w_pick_lam = lam_req;
`else
    // Tie goes to the requester that did not own the previous cycle.
    assign w_pick_lam = lam_req & (~host_req | ~r_grant_lam);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_S_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic. One counter serves both the setup window (counting
    // down) and the handshake timeout (counting up from zero).
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;
        w_start       = 1'b0;
        w_cnt_inc     = r_cnt + 1'b1;
        case (r_state)
            c_S_IDLE: begin
                if (host_req | lam_req) begin
                    w_start       = 1'b1;
                    w_cnt_nxt     = c_SETUP_LAST;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = c_S_SETUP;
                end
            end
            c_S_SETUP: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_S_WAIT_LO;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_S_WAIT_LO: begin
                w_cnt_nxt = w_cnt_inc;
                // The cycle cannot complete from here, so the timeout wins
                // even if rdy is seen low on the same edge.
                if (w_cnt_inc == c_TIMEOUT) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = c_S_RELEASE;
                end else if (!rdy) begin
                    w_state_nxt = c_S_WAIT_HI;
                end
            end
            c_S_WAIT_HI: begin
                w_cnt_nxt = w_cnt_inc;
                // A completion on the final allowed clock counts as success.
                if (rdy) begin
                    w_state_nxt = c_S_RELEASE;
                end else if (w_cnt_inc == c_TIMEOUT) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = c_S_RELEASE;
                end
            end
            c_S_RELEASE: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Cycle owner and a/w are captured only when a cycle is accepted and
    // then held through RELEASE and the following idle period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a         <= 2'd0;
            r_w         <= 1'b0;
            r_grant_lam <= 1'b1;
        end else if (w_start) begin
            r_grant_lam <= w_pick_lam;
            r_a         <= w_pick_lam ? lam_a : host_a;
            r_w         <= w_pick_lam ? lam_w : host_w;
        end
    end

    assign a           = r_a;
    assign w           = r_w;
    assign grant_lam   = r_grant_lam;
    assign busy        = (r_state != c_S_IDLE);
    assign sel_n       = ~((r_state == c_S_WAIT_LO) | (r_state == c_S_WAIT_HI));
    assign host_done   = (r_state == c_S_RELEASE) & ~r_grant_lam;
    assign lam_done    = (r_state == c_S_RELEASE) &  r_grant_lam;
    assign timeout_err = (r_state == c_S_RELEASE) &  r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_camac_cycle_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_camac_cycle_arbiter
//  Description : Self-checking bench for camac_cycle_arbiter. A behavioural
//                automate answers sel_n with programmable rdy delays; each
//                cycle's winner, a/w, setup length, select length, done and
//                timeout flags are predicted at transaction level.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_camac_cycle_arbiter;

    localparam int SETUP_CYCLES   = 2;
    localparam int TIMEOUT_CYCLES = 16;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       host_req = 1'b0;
    logic [1:0] host_a   = 2'd0;
    logic       host_w   = 1'b0;
    logic       lam_req  = 1'b0;
    logic [1:0] lam_a    = 2'd0;
    logic       lam_w    = 1'b0;
    logic       rdy      = 1'b1;
    logic       host_done;
    logic       lam_done;
    logic [1:0] a;
    logic       w;
    logic       sel_n;
    logic       busy;
    logic       timeout_err;
    logic       grant_lam;

    int vecs = 0;
    int errs = 0;

    // Reference state: owner of the last completed cycle.
    bit m_grant_lam = 1'b1;

    // Automate behaviour: rdy drops a_lo clocks after sel_n falls and stays
    // low for a_hi clocks; a_stuck keeps rdy high forever.
    int a_lo    = 1;
    int a_hi    = 3;
    bit a_stuck = 1'b0;
    int ak      = 0;

    always #5 clk = ~clk;

    camac_cycle_arbiter #(
        .SETUP_CYCLES   (SETUP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host_req    (host_req),
        .host_a      (host_a),
        .host_w      (host_w),
        .host_done   (host_done),
        .lam_req     (lam_req),
        .lam_a       (lam_a),
        .lam_w       (lam_w),
        .lam_done    (lam_done),
        .a           (a),
        .w           (w),
        .sel_n       (sel_n),
        .rdy         (rdy),
        .busy        (busy),
        .timeout_err (timeout_err),
        .grant_lam   (grant_lam)
    );

    always @(negedge clk) begin
        if (sel_n !== 1'b0) begin
            ak  = 0;
            rdy = 1'b1;
        end else begin
            if (a_stuck)
                rdy = 1'b1;
            else
                rdy = !(ak >= a_lo && ak < a_lo + a_hi);
            ak++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one arbitrated cycle. Called at a negedge with the DUT idle;
    // returns at the negedge after RELEASE (DUT idle again).
    task automatic txn(input bit hreq, input bit lreq,
                       input logic [1:0] ha, input logic hw,
                       input logic [1:0] la, input logic lw,
                       input int lo, input int hi, input bit stuck,
                       input bit drop_mid, input bit hold);
        bit         win_lam;
        logic [1:0] exp_a;
        logic       exp_w;
        int         exp_low;
        bit         exp_to;
        int         n_setup;
        int         n_low;

        host_a = ha; host_w = hw; lam_a = la; lam_w = lw;
        host_req = hreq; lam_req = lreq;
        a_lo = lo; a_hi = hi; a_stuck = stuck;

        if (hreq && lreq) begin
`ifdef ARB_LAM_PRIORITY_EN
            win_lam = 1'b1;
`else
            win_lam = ~m_grant_lam;
`endif
        end else begin
            win_lam = lreq;
        end
        exp_a = win_lam ? la : ha;
        exp_w = win_lam ? lw : hw;
        // rdy seen low lo+1 edges after sel_n falls, seen high hi edges later
        if (stuck || (lo + hi + 1) > TIMEOUT_CYCLES) begin
            exp_low = TIMEOUT_CYCLES;
            exp_to  = 1'b1;
        end else begin
            exp_low = lo + hi + 1;
            exp_to  = 1'b0;
        end

        @(negedge clk);
        chk("busy_on_accept", busy, 1);
        chk("grant_lam", grant_lam, win_lam);
        chk("a_latched", a, exp_a);
        chk("w_latched", w, exp_w);

        n_setup = 0;
        while (sel_n === 1'b1 && n_setup < 64) begin
            n_setup++;
            @(negedge clk);
        end
        chk("setup_clocks", n_setup, SETUP_CYCLES);

        n_low = 0;
        while (sel_n === 1'b0 && n_low < 2048) begin
            if (drop_mid && n_low == 0) begin
                host_req = 1'b0;
                lam_req  = 1'b0;
            end
            n_low++;
            @(negedge clk);
        end
        chk("sel_low_clocks", n_low, exp_low);
        chk("host_done_pulse", host_done, !win_lam);
        chk("lam_done_pulse", lam_done, win_lam);
        chk("timeout_err", timeout_err, exp_to);
        chk("busy_in_release", busy, 1);
        chk("a_held", {w, a}, {exp_w, exp_a});

        if (!hold) begin
            host_req = 1'b0;
            lam_req  = 1'b0;
        end
        m_grant_lam = win_lam;

        @(negedge clk);
        chk("idle_after_release", {busy, sel_n, host_done, lam_done, timeout_err}, 5'b01000);
        chk("aw_hold_idle", {w, a}, {exp_w, exp_a});
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("stays_idle", {busy, sel_n}, 2'b01);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {a, w, sel_n, busy, host_done, lam_done, timeout_err, grant_lam},
            {2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        reset = 1'b0;
        m_grant_lam = 1'b1;
    endtask

    initial begin
        int         n;
        int         sel;
        int         lo;
        int         hi;
        bit         st;

        // Reset state
        @(negedge clk);
        do_reset();

        // HOST-only cycle, a=2, w=1, rdy drops 1 clk after sel_n, 3 low
        txn(1, 0, 2'd2, 1'b1, 2'd1, 1'b0, 1, 3, 0, 0, 0);

        // Tie right after reset, requests held for two cycles
        do_reset();
`ifdef ARB_LAM_PRIORITY_EN
        txn(1, 1, 2'd1, 1'b0, 2'd3, 1'b1, 1, 3, 0, 0, 1);
        txn(1, 0, 2'd1, 1'b0, 2'd3, 1'b1, 1, 3, 0, 0, 0);
`else
        txn(1, 1, 2'd1, 1'b0, 2'd3, 1'b1, 1, 3, 0, 0, 1);
        txn(1, 1, 2'd1, 1'b0, 2'd3, 1'b1, 1, 3, 0, 0, 0);
`endif

        // rdy stuck high: full timeout
        txn(1, 0, 2'd3, 1'b0, 2'd0, 1'b0, 0, 1, 1, 0, 0);
        check_idle(2);

        // Completion exactly on the last allowed clock, then one past it
        txn(0, 1, 2'd2, 1'b1, 2'd1, 1'b0, 5, 10, 0, 0, 0);
        txn(0, 1, 2'd2, 1'b1, 2'd1, 1'b0, 5, 11, 0, 0, 0);
        // rdy already low on entry to WAIT_LO
        txn(1, 0, 2'd1, 1'b1, 2'd0, 1'b0, 0, 2, 0, 0, 0);

        // Reset while in WAIT_HI
        host_req = 1'b1; host_a = 2'd3; host_w = 1'b1; lam_req = 1'b0;
        a_lo = 1; a_hi = 10; a_stuck = 1'b0;
        n = 0;
        while (sel_n !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        chk("in_wait_hi", {sel_n, busy}, 2'b01);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_cycle", {a, w, sel_n, busy, host_done, lam_done, timeout_err, grant_lam},
            {2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        reset    = 1'b0;
        host_req = 1'b0;
        m_grant_lam = 1'b1;
        check_idle(2);

        // HOST drops its request during WAIT_LO
        txn(1, 0, 2'd2, 1'b0, 2'd0, 1'b0, 2, 2, 0, 1, 0);
        check_idle(4);

        // LAM held through three back-to-back cycles
        for (int k = 0; k < 3; k++)
            txn(0, 1, 2'd0, 1'b0, 2'($urandom), 1'($urandom), 1, 2, 0, 0, (k < 2));
        check_idle(2);

        // Randomised traffic
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(2, 0);
            lo  = $urandom_range(4, 0);
            hi  = $urandom_range(14, 1);
            st  = ($urandom_range(7, 0) == 0);
            txn((sel != 1), (sel != 0), 2'($urandom), 1'($urandom),
                2'($urandom), 1'($urandom), lo, hi, st, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, vectors %0d", vecs);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/camac_cycle_arbiter.md
Name: camac_cycle_arbiter

Overview:
- Sequences single CAMAC dataway cycles through the micro-program automate for two requesters: ISA host port (HOST) and LAM-service poller (LAM).
- Arbitrates between the requesters and drives the automate's a/w/sel inputs with setup timing.
- Waits for the automate's rdy handshake and reports done/timeout back to the winning requester.
- Sits between the ISA decode logic and micro_program_automate on the sm2201 interface board.

Parameters:
SETUP_CYCLES, 2, clocks a/w are held stable before sel_n asserts (legal range 1..15)
TIMEOUT_CYCLES, 255, max clocks from sel_n assertion to rdy completion before abort (legal range 2..1023)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
host_req  input  1  HOST cycle request; level, held until host_done
host_a  input  2  HOST subaddress
host_w  input  1  HOST direction, 1 = write
host_done  output  1  one-clock pulse: HOST cycle finished (ok or timeout)
lam_req  input  1  LAM cycle request; level, held until lam_done
lam_a  input  2  LAM subaddress
lam_w  input  1  LAM direction
lam_done  output  1  one-clock pulse: LAM cycle finished
a  output  2  subaddress to automate
w  output  1  direction to automate
sel_n  output  1  active-low select to automate
rdy  input  1  automate ready: high idle, low while cycle in progress
busy  output  1  high in every state except IDLE
timeout_err  output  1  one-clock pulse together with done when a cycle aborted
grant_lam  output  1  owner of current/last cycle: 0 HOST, 1 LAM

Behaviour:
- Reset: state IDLE; a=0, w=0, sel_n=1, busy=0, host_done=0, lam_done=0, timeout_err=0, grant_lam=1 (so HOST wins the first tie). Reset in any state returns to IDLE on that edge. No done pulse for the aborted cycle.
- States: IDLE, SETUP, WAIT_LO, WAIT_HI, RELEASE.
- IDLE: on an edge with any request, latch winner's a/w into a/w, set grant_lam, load setup counter, go to SETUP.
- Tie (both requests high on the same edge): round-robin; winner is the requester not equal to the current grant_lam.
- SETUP: sel_n=1, a/w stable. After SETUP_CYCLES clocks, assert sel_n=0, clear timeout counter, go to WAIT_LO.
- WAIT_LO: sel_n=0; rdy sampled low -> WAIT_HI.
- WAIT_HI: sel_n=0; rdy sampled high -> RELEASE.
- Timeout counter increments every clock in WAIT_LO/WAIT_HI. On reaching TIMEOUT_CYCLES, go to RELEASE with timeout flag set.
- RELEASE (1 clock): sel_n=1; pulse the winner's done; timeout_err pulses with it if aborted; a/w hold their values; next state IDLE.
- Latency, HOST alone, automate instantly responsive: req seen at edge 0; sel_n low from edge SETUP_CYCLES; done at earliest edge SETUP_CYCLES+3.
- A requester may re-arbitrate only from IDLE, one clock after RELEASE. Back-to-back requests therefore have at least 1 idle clock between cycles.
- A request dropped mid-cycle is ignored: the cycle completes and the done pulse is still issued.
- a/w/grant_lam change only on the IDLE->SETUP transition.
- Requests arriving during busy are not queued; they are just re-sampled in IDLE.
- rdy already low when entering WAIT_LO is legal and advances on the next edge.

Optional Feature:
ARB_LAM_PRIORITY_EN
- Defined: fixed priority; LAM wins every tie and grant_lam history is ignored.
- Not defined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, HOST-only cycle with SETUP_CYCLES=2, host_a=2, host_w=1; bench automate drops rdy 1 clk after sel_n low and raises it 3 clks later -> a=2, w=1 two clocks before sel_n=0; host_done single pulse; lam_done=0; grant_lam=0; busy low after RELEASE.
2. Both requests asserted on the same edge right after reset, held for two cycles -> HOST served first, then LAM. grant_lam sequence 0,1. With ARB_LAM_PRIORITY_EN: LAM first, then HOST.
3. TIMEOUT_CYCLES=16, rdy stuck high -> sel_n low for exactly 16 clocks; timeout_err and host_done pulse together; sel_n=1; state IDLE.
4. Reset asserted while in WAIT_HI -> next edge sel_n=1, busy=0, a=0, w=0; no done or timeout pulse.
5. HOST drops host_req during WAIT_LO -> cycle finishes, host_done pulses once, no new cycle starts.
6. LAM held continuously for 3 cycles, rdy toggling normally -> three lam_done pulses, sel_n high for at least 1+SETUP_CYCLES clocks between cycles, a tracks lam_a sampled at each IDLE exit.
